// File: rtl/data_mem_interface_pkg.sv
// Shared bus definitions for the data-memory stage: state encoding, bus widths
// and the lane-masking helper used when latching write data.
package data_mem_interface_pkg;

  localparam int unsigned BE_W   = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [BE_W-1:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Zero every byte lane whose enable is clear.
  function automatic logic [DATA_W-1:0] mask_lanes(input logic [DATA_W-1:0] data,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] masked;
    masked = '0;
    for (int b = 0; b < BE_W; b++) begin
      masked[8*b +: 8] = be[b] ? data[8*b +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/data_mem_interface.sv
// Sequential data-memory stage: req/ready handshake toward the CPU, fixed
// wait-state access toward a word-addressed memory, rejection of illegal accesses.
module data_mem_interface
  import data_mem_interface_pkg::*;
#(
  parameter int BUS_WORD_ADDR_WIDTH = 16,
  parameter int MEM_WORDS           = 16384,
  parameter int WAIT_STATES         = 1
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_n,
  input  logic                           i_Req,
  input  logic                           i_We,
  input  logic [BUS_WORD_ADDR_WIDTH-1:0] i_Addr,
  input  logic [BE_W-1:0]                i_ByteEn,
  input  logic [DATA_W-1:0]              i_WD,
  output logic [DATA_W-1:0]              o_RD,
  output logic                           o_Ready,
  output logic                           o_Err,
  output logic                           o_Busy,
  output logic                           o_Mem_En,
  output logic                           o_Mem_We,
  output logic [BUS_WORD_ADDR_WIDTH-1:0] o_Mem_Addr,
  output logic [BE_W-1:0]                o_Mem_ByteEn,
  output logic [DATA_W-1:0]              o_Mem_WD,
  input  logic [DATA_W-1:0]              i_Mem_RD
);

  localparam int CNT_W = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  state_e                         state_q;
  logic                           we_q;
  logic                           err_q;
  logic [BUS_WORD_ADDR_WIDTH-1:0] addr_q;
  logic [BE_W-1:0]                be_q;
  logic [DATA_W-1:0]              wd_q;
  logic [DATA_W-1:0]              rd_q;
  logic [CNT_W-1:0]               cnt_q;

  logic [DATA_W-1:0]              wd_d;
  logic                           reject_d;

  // NOTE: every signal assigned in always_comb gets a value on every path; a missing default infers a latch.
  always_comb begin
    wd_d     = mask_lanes(i_WD, i_ByteEn);
    reject_d = (i_ByteEn == '0) || (32'(i_Addr) >= 32'(MEM_WORDS));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_Req) begin
            we_q   <= i_We;
            addr_q <= i_Addr;
            be_q   <= i_ByteEn;
            wd_q   <= wd_d;
            err_q  <= reject_d;
            cnt_q  <= CNT_LOAD;
            if (reject_d) begin
              rd_q    <= '0;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!we_q) rd_q <= i_Mem_RD;
            state_q <= ST_DONE;
          end
        end
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // The write strobe only fires in the final access cycle, so a write commits exactly once.
  assign o_Busy       = (state_q != ST_IDLE);
  assign o_Mem_En     = (state_q == ST_ACCESS);
  assign o_Mem_We     = o_Mem_En && we_q && (cnt_q == '0);
  assign o_Ready      = (state_q == ST_DONE);
  assign o_Err        = o_Ready && err_q;
  assign o_RD         = rd_q;
  assign o_Mem_Addr   = addr_q;
  assign o_Mem_ByteEn = be_q;
  assign o_Mem_WD     = wd_q;

endmodule

// File: tb/tb_data_mem_interface.sv
// Self-checking bench: two instances (1 and 3 wait states) against a transaction-level
// model of memory contents, latency and error rules.
module tb_data_mem_interface;

  localparam int AW        = 16;
  localparam int MEM_WORDS = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst3_n, req1, req3;
  logic c_we;
  logic [AW-1:0] c_addr;
  logic [3:0] c_be;
  logic [31:0] c_wd;

  logic [31:0] rd1, rd3, mwd1, mwd3, mrd1, mrd3;
  logic ready1, ready3, err1, err3, busy1, busy3, en1, en3, mwe1, mwe3;
  logic [AW-1:0] maddr1, maddr3;
  logic [3:0] mbe1, mbe3;

  data_mem_interface #(.BUS_WORD_ADDR_WIDTH(AW), .MEM_WORDS(MEM_WORDS), .WAIT_STATES(1)) dut1 (
    .i_Clk(clk), .i_Rst_n(rst1_n), .i_Req(req1), .i_We(c_we), .i_Addr(c_addr),
    .i_ByteEn(c_be), .i_WD(c_wd), .o_RD(rd1), .o_Ready(ready1), .o_Err(err1),
    .o_Busy(busy1), .o_Mem_En(en1), .o_Mem_We(mwe1), .o_Mem_Addr(maddr1),
    .o_Mem_ByteEn(mbe1), .o_Mem_WD(mwd1), .i_Mem_RD(mrd1));

  data_mem_interface #(.BUS_WORD_ADDR_WIDTH(AW), .MEM_WORDS(MEM_WORDS), .WAIT_STATES(3)) dut3 (
    .i_Clk(clk), .i_Rst_n(rst3_n), .i_Req(req3), .i_We(c_we), .i_Addr(c_addr),
    .i_ByteEn(c_be), .i_WD(c_wd), .o_RD(rd3), .o_Ready(ready3), .o_Err(err3),
    .o_Busy(busy3), .o_Mem_En(en3), .o_Mem_We(mwe3), .o_Mem_Addr(maddr3),
    .o_Mem_ByteEn(mbe3), .o_Mem_WD(mwd3), .i_Mem_RD(mrd3));

  // Behavioural memories attached to each DUT's memory port.
  logic [31:0] mem1 [0:MEM_WORDS-1];
  logic [31:0] mem3 [0:MEM_WORDS-1];
  assign mrd1 = mem1[maddr1[13:0]];
  assign mrd3 = mem3[maddr3[13:0]];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (en1 && mwe1 && mbe1[b]) mem1[maddr1[13:0]][8*b +: 8] <= mwd1[8*b +: 8];
      if (en3 && mwe3 && mbe3[b]) mem3[maddr3[13:0]][8*b +: 8] <= mwd3[8*b +: 8];
    end
  end

  // Observed signals of whichever instance the current transaction targets.
  bit sel;
  logic [31:0] o_rd, o_mwd;
  logic o_ready, o_err, o_busy, o_en, o_mwe;
  logic [AW-1:0] o_maddr;
  logic [3:0] o_mbe;
  assign o_rd    = sel ? rd3    : rd1;
  assign o_mwd   = sel ? mwd3   : mwd1;
  assign o_ready = sel ? ready3 : ready1;
  assign o_err   = sel ? err3   : err1;
  assign o_busy  = sel ? busy3  : busy1;
  assign o_en    = sel ? en3    : en1;
  assign o_mwe   = sel ? mwe3   : mwe1;
  assign o_maddr = sel ? maddr3 : maddr1;
  assign o_mbe   = sel ? mbe3   : mbe1;

  // Reference model: expected memory contents per instance and last completed read word.
  logic [31:0] exp_mem [int];
  logic [31:0] exp_rd [2];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] model_word(input bit s, input logic [AW-1:0] a);
    int key;
    key = (s ? 65536 : 0) + int'(a);
    return exp_mem.exists(key) ? exp_mem[key] : 32'h0;
  endfunction

  task automatic do_txn(input bit s, input logic we, input logic [AW-1:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    int ws, exp_edge, ready_edge, en_cnt, we_cnt, we_idx, key;
    logic err;
    logic [31:0] mask;
    bit got;
    ws       = s ? 3 : 1;
    err      = (be == 4'b0000) || (int'(addr) >= MEM_WORDS);
    mask     = lane_mask(be);
    exp_edge = err ? 1 : ws + 2;
    key      = (s ? 65536 : 0) + int'(addr);
    if (err)      exp_rd[s] = 32'h0;
    else if (!we) exp_rd[s] = model_word(s, addr);
    else          exp_mem[key] = (model_word(s, addr) & ~mask) | (wd & mask);

    @(negedge clk);
    sel = s;
    c_we = we; c_addr = addr; c_be = be; c_wd = wd;
    if (s) req3 = 1'b1; else req1 = 1'b1;
    got = 0; ready_edge = 0; en_cnt = 0; we_cnt = 0; we_idx = 0;
    for (int e = 1; e <= 20 && !got; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        // Inputs other than i_Req must be ignored once the access is accepted.
        c_we = ~we; c_addr = AW'($urandom); c_be = 4'($urandom); c_wd = $urandom;
      end
      if (o_en) begin
        en_cnt++;
        if (en_cnt == 1) begin
          check("mem_addr", 32'(o_maddr), 32'(addr));
          check("mem_byteen", 32'(o_mbe), 32'(be));
          check("mem_wd", o_mwd, wd & mask);
        end
      end
      if (o_mwe) begin
        we_cnt++;
        we_idx = en_cnt;
      end
      if (o_ready) begin
        got = 1;
        ready_edge = e;
        if (s) req3 = 1'b0; else req1 = 1'b0;
        check("err", 32'(o_err), 32'(err));
        check("rd", o_rd, exp_rd[s]);
      end
    end
    if (s) req3 = 1'b0; else req1 = 1'b0;
    check("ready_seen", 32'(got), 32'd1);
    check("ready_latency", ready_edge, exp_edge);
    check("mem_en_cycles", en_cnt, err ? 0 : ws + 1);
    check("mem_we_cycles", we_cnt, (we && !err) ? 1 : 0);
    if (we && !err) check("mem_we_last_cycle", we_idx, ws + 1);
    @(posedge clk); #1;
    check("ready_single_pulse", 32'(o_ready), 32'd0);
    check("idle_after_done", 32'(o_busy), 32'd0);
    check("rd_held", o_rd, exp_rd[s]);
  endtask

  initial begin
    int abort_we, abort_rdy;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem1[i] = 32'h0;
      mem3[i] = 32'h0;
    end
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    sel = 0;
    rst1_n = 1'b0; rst3_n = 1'b0;
    req1 = 1'b1; req3 = 1'b1;
    c_we = 1'b1; c_addr = 16'h0004; c_be = 4'hF; c_wd = 32'hA5A5A5A5;

    // Reset held with a pending request: everything stays zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", rd1, 32'h0);
    check("rst_ready", 32'(ready1), 32'h0);
    check("rst_err", 32'(err1), 32'h0);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_mem_en", 32'(en1), 32'h0);
    check("rst_mem_we", 32'(mwe1), 32'h0);
    check("rst_mem_addr", 32'(maddr1), 32'h0);
    check("rst_mem_byteen", 32'(mbe1), 32'h0);
    check("rst_mem_wd", mwd1, 32'h0);
    check("rst3_busy", 32'(busy3), 32'h0);
    req1 = 1'b0; req3 = 1'b0;
    rst1_n = 1'b1; rst3_n = 1'b1;

    // Directed: word write, byte write, read-back, two error kinds.
    do_txn(0, 1'b1, 16'h0004, 4'b1111, 32'hDEADBEEF);
    do_txn(0, 1'b1, 16'h0005, 4'b0100, 32'h11223344);
    do_txn(0, 1'b0, 16'h0004, 4'b1111, 32'h0);
    do_txn(0, 1'b0, 16'h0005, 4'b1111, 32'h0);
    do_txn(0, 1'b0, 16'(MEM_WORDS), 4'b1111, 32'h0);
    do_txn(0, 1'b1, 16'h0006, 4'b0000, 32'hFFFFFFFF);
    do_txn(0, 1'b0, 16'hFFFF, 4'b1111, 32'h0);
    do_txn(0, 1'b1, 16'(MEM_WORDS - 1), 4'b1001, 32'h89ABCDEF);
    do_txn(0, 1'b0, 16'(MEM_WORDS - 1), 4'b1111, 32'h0);

    // Reset mid-write on the 3-wait-state instance, before its final access cycle.
    @(negedge clk);
    sel = 1;
    c_we = 1'b1; c_addr = 16'h0009; c_be = 4'hF; c_wd = 32'hCAFEF00D;
    req3 = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 32'(busy3), 32'd1);
    check("abort_mem_en", 32'(en3), 32'd1);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    check("abort_busy_cleared", 32'(busy3), 32'd0);
    check("abort_mem_en_cleared", 32'(en3), 32'd0);
    req3 = 1'b0;
    abort_we = 0; abort_rdy = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (mwe3) abort_we++;
      if (ready3) abort_rdy++;
      if (c == 2) rst3_n = 1'b1;
    end
    check("abort_no_we", abort_we, 0);
    check("abort_no_ready", abort_rdy, 0);
    check("abort_mem_untouched", mem3[9], 32'h0);
    exp_rd[1] = 32'h0;
    do_txn(1, 1'b0, 16'h0009, 4'b1111, 32'h0);
    do_txn(1, 1'b1, 16'h0009, 4'b0011, 32'h12345678);
    do_txn(1, 1'b0, 16'h0009, 4'b1111, 32'h0);

    // Randomized traffic on both instances against the model.
    for (int t = 0; t < 40; t++) begin
      bit s;
      logic w;
      logic [AW-1:0] a;
      logic [3:0] be;
      s  = ($urandom_range(0, 3) == 0);
      w  = 1'($urandom);
      a  = AW'($urandom_range(0, 15));
      be = 4'($urandom);
      case ($urandom_range(0, 9))
        0: a = AW'($urandom_range(MEM_WORDS, 65535));
        1: be = 4'b0000;
        default: ;
      endcase
      do_txn(s, w, a, be, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_interface.md
Name: data_mem_interface

Overview:
- Sequential downstream stage of the CPU bus controller. Consumes the word address, byte enables and aligned write data the controller produces, and returns the raw 32-bit read word to it.
- Runs a req/ready handshake toward the CPU side.
- Drives a word-addressed memory/peripheral port with a fixed, parameterised number of wait states.
- Flags illegal accesses (empty byte mask, out-of-range address) without touching memory.

Parameters:
- BUS_WORD_ADDR_WIDTH, 16, width of the word address; must match the bus controller.
- MEM_WORDS, 16384, number of implemented words; word addresses >= MEM_WORDS are errors.
- WAIT_STATES, 1, extra memory cycles per access (0..15).

Ports:
- i_Clk  in  1  system clock, rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Req  in  1  access request; held by the CPU until o_Ready.
- i_We  in  1  1 = write, 0 = read.
- i_Addr  in  BUS_WORD_ADDR_WIDTH  word address from the bus controller.
- i_ByteEn  in  4  byte lane enables from the bus controller.
- i_WD  in  32  lane-aligned write data.
- o_RD  out  32  raw read word; valid in the o_Ready cycle and held until the next completion.
- o_Ready  out  1  one-cycle completion pulse.
- o_Err  out  1  qualifies o_Ready; access was rejected.
- o_Busy  out  1  high in any state other than IDLE.
- o_Mem_En  out  1  memory select.
- o_Mem_We  out  1  memory write strobe.
- o_Mem_Addr  out  BUS_WORD_ADDR_WIDTH  latched word address.
- o_Mem_ByteEn  out  4  latched byte enables.
- o_Mem_WD  out  32  latched write data; disabled lanes are forced to 0.
- i_Mem_RD  in  32  memory read data; combinational, valid during the last ACCESS cycle.

Behaviour:
- Reset: i_Rst_n low forces state IDLE immediately and zeroes every output and internal register (o_RD = 0 included).
  - Reset mid-access aborts the access. No write strobe is issued after reset assertion and no o_Ready is produced.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - o_Busy = 0 and o_Mem_En = 0.
  - On an edge with i_Req = 1, latch i_We, i_Addr, i_ByteEn and the masked i_WD.
  - If i_ByteEn == 0 or i_Addr >= MEM_WORDS: set r_Err = 1, go to DONE; memory is never enabled.
  - Otherwise: load wait counter = WAIT_STATES, go to ACCESS.
- ACCESS:
  - o_Mem_En = 1; o_Mem_Addr, o_Mem_ByteEn and o_Mem_WD come from the latches.
  - o_Mem_We = latched We AND (counter == 0). A write commits exactly once, in the final ACCESS cycle.
  - Each edge with counter != 0 decrements the counter.
  - The edge with counter == 0 captures i_Mem_RD into o_RD (reads only; writes leave o_RD unchanged) and goes to DONE.
  - ACCESS lasts WAIT_STATES+1 cycles.
- DONE:
  - o_Ready = 1 and o_Err = r_Err for exactly one cycle; o_Mem_En = 0. Go to IDLE unconditionally.
  - On error, o_RD is forced to 0.
- Latency: request accepted on edge N. o_Ready is high during the cycle after edge N+WAIT_STATES+1, i.e. WAIT_STATES+2 cycles after acceptance.
  - Error path: o_Ready is high the cycle after edge N.
  - Peak throughput: one access per WAIT_STATES+3 cycles.
- Inputs other than i_Req are ignored outside IDLE; changes mid-access have no effect.
- i_Req still high in DONE is ignored. If it is still high in the following IDLE cycle it starts a new access, so the CPU must drop i_Req in the o_Ready cycle.
- Counter width = max(1, clog2(WAIT_STATES+1)). WAIT_STATES = 0 gives a single ACCESS cycle.
- Read data bytes are passed unmasked; lane selection and sign extension are done upstream.

Decomposition:
- Shared bus package holds:
  - state encodings IDLE=2'd0, ACCESS=2'd1, DONE=2'd2;
  - byte-enable width 4 and data width 32;
  - the all-lanes constant 4'b1111.
- No sub-module. The wait counter stays inline; it is too small to justify its own module.

Test Plan:
- Reset: hold i_Rst_n = 0 with i_Req = 1 -> all outputs 0 and state IDLE.
- Word write, WAIT_STATES = 1: i_Addr = 0x0004, ByteEn = 1111, WD = 0xDEADBEEF -> o_Mem_En high 2 cycles, o_Mem_We high only in the 2nd, o_Ready 3 cycles after acceptance, o_Err = 0.
- Byte write: ByteEn = 0100, WD = 0x11223344 -> o_Mem_WD = 0x00220000.
- Read-back of addr 0x0004 with i_Mem_RD = 0xDEADBEEF -> o_RD = 0xDEADBEEF in the o_Ready cycle; o_Mem_We never asserts.
- Errors: i_Addr = MEM_WORDS, then a separate request with ByteEn = 0000 -> each gives o_Ready with o_Err = 1 one cycle after acceptance, o_Mem_En never asserts, o_RD = 0.
- Reset pulse while in ACCESS of a write, WAIT_STATES = 3, asserted before the final ACCESS cycle -> o_Mem_We never asserts, no o_Ready pulse, next request completes normally.
